// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues one prefetch request per cycle and queues {pc, instr, comp} for decode.
// Define FQ_COMPRESSED_EN to accept 16-bit RVC instructions (2-byte PC steps).
module fetch_queue #(
   parameter int unsigned FQ_DEPTH = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redir_valid,
   input  logic        redir_fence,
   input  logic [31:0] redir_addr,
   output logic        pf_valid,
   output logic        pf_fence,
   output logic [31:0] pf_addr,
   input  logic [31:0] pf_rdata,
   input  logic        pf_ready,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr,
   output logic        dec_comp
);
   localparam int unsigned N = 1 << FQ_DEPTH;
   localparam logic [FQ_DEPTH:0] FULL = (FQ_DEPTH+1)'(N);
`ifdef FQ_COMPRESSED_EN
   localparam logic [31:0] AMASK = 32'hffff_fffe;
`else
   localparam logic [31:0] AMASK = 32'hffff_fffc;
`endif
   logic [31:0]         pc_q, pc_d;
   logic [FQ_DEPTH:0]   cnt_q, cnt_d;
   logic [FQ_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
   logic                fence_q, fence_d;
   logic [31:0]         pc_mem [N];
   logic [31:0]         instr_mem [N];
   logic                comp_mem [N];
   logic                push, pop, comp;
   logic [31:0]         instr;

   always_comb begin
`ifdef FQ_COMPRESSED_EN
      comp = pf_rdata[1:0] != 2'b11;
      instr = comp ? {16'h0, pf_rdata[15:0]} : pf_rdata;
`else
      comp = 1'b0;
      instr = pf_rdata;
`endif
      pf_valid = rst && !redir_valid && cnt_q != FULL;
      pf_fence = rst && fence_q && !redir_valid;
      pf_addr = pc_q;
      // the fence pulse occupies the request slot; its response is discarded
      push = pf_valid && pf_ready && !fence_q;
      dec_valid = rst && cnt_q != '0;
      pop = dec_valid && dec_ready && !redir_valid;
      dec_pc = dec_valid ? pc_mem[rd_q] : '0;
      dec_instr = dec_valid ? instr_mem[rd_q] : '0;
      dec_comp = dec_valid && comp_mem[rd_q];
   end

   always_comb begin
      pc_d = redir_valid ? (redir_addr & AMASK) : push ? pc_q + (comp ? 32'd2 : 32'd4) : pc_q;
      cnt_d = redir_valid ? '0 : cnt_q + (FQ_DEPTH+1)'(push) - (FQ_DEPTH+1)'(pop);
      rd_d = redir_valid ? '0 : rd_q + FQ_DEPTH'(pop);
      wr_d = redir_valid ? '0 : wr_q + FQ_DEPTH'(push);
      fence_d = redir_valid && redir_fence;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q <= RESET_PC & AMASK;
         cnt_q <= '0;
         rd_q <= '0;
         wr_q <= '0;
         fence_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         cnt_q <= cnt_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
         fence_q <= fence_d;
      end
      if (push) begin
         pc_mem[wr_q] <= pc_q;
         instr_mem[wr_q] <= instr;
         comp_mem[wr_q] <= comp;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_fetch_queue;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        comp;
   } ent_t;

`ifdef FQ_COMPRESSED_EN
   localparam logic [31:0] AMASK = 32'hffff_fffe;
   localparam bit RVC = 1'b1;
`else
   localparam logic [31:0] AMASK = 32'hffff_fffc;
   localparam bit RVC = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, redir_valid, redir_fence, pf_ready, dec_ready;
   logic [31:0] redir_addr, pf_rdata;
   logic        pf_valid, pf_fence, dec_valid, dec_comp;
   logic [31:0] pf_addr, dec_pc, dec_instr;

   int checks = 0;
   int errors = 0;
   ent_t q[$];
   logic [31:0] mpc;
   bit mfence;

   fetch_queue #(.FQ_DEPTH(2), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_fence(redir_fence),
      .redir_addr(redir_addr), .pf_valid(pf_valid), .pf_fence(pf_fence), .pf_addr(pf_addr),
      .pf_rdata(pf_rdata), .pf_ready(pf_ready), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_comp(dec_comp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Compare outputs with the model, take one clock edge, then advance the model.
   task automatic cyc();
      bit ev, ef, dv, cmp, pushed;
      ent_t e;
      #1;
      ev = rst && !redir_valid && q.size() < DEPTH;
      ef = rst && mfence && !redir_valid;
      dv = rst && q.size() != 0;
      chk("pf_valid", {31'b0, pf_valid}, {31'b0, ev});
      chk("pf_fence", {31'b0, pf_fence}, {31'b0, ef});
      if (ev) chk("pf_addr", pf_addr, mpc);
      chk("dec_valid", {31'b0, dec_valid}, {31'b0, dv});
      if (dv) begin
         chk("dec_pc", dec_pc, q[0].pc);
         chk("dec_instr", dec_instr, q[0].instr);
         chk("dec_comp", {31'b0, dec_comp}, {31'b0, q[0].comp});
      end else begin
         chk("dec_pc0", dec_pc, 32'h0);
         chk("dec_instr0", dec_instr, 32'h0);
         chk("dec_comp0", {31'b0, dec_comp}, 32'h0);
      end
      cmp = RVC && pf_rdata[1:0] != 2'b11;
      e.pc = mpc;
      e.comp = cmp;
      e.instr = cmp ? (pf_rdata & 32'h0000_ffff) : pf_rdata;
      pushed = ev && pf_ready && !mfence;
      @(posedge clk);
      if (!rst) begin
         q.delete();
         mpc = 32'h0 & AMASK;
         mfence = 1'b0;
      end else if (redir_valid) begin
         q.delete();
         mpc = redir_addr & AMASK;
         mfence = redir_fence;
      end else begin
         if (dv && dec_ready) void'(q.pop_front());
         if (pushed) begin
            q.push_back(e);
            mpc = mpc + (cmp ? 32'd2 : 32'd4);
         end
         mfence = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic redirect(input logic [31:0] a, input logic f);
      redir_valid = 1'b1;
      redir_fence = f;
      redir_addr = a;
      cyc();
      redir_valid = 1'b0;
      redir_fence = 1'b0;
   endtask

   initial begin
      rst = 1'b0; redir_valid = 1'b0; redir_fence = 1'b0; redir_addr = '0;
      pf_ready = 1'b1; pf_rdata = 32'h0000_0013; dec_ready = 1'b0;
      mpc = 32'h0; mfence = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_pf_valid", {31'b0, pf_valid}, 32'h0);
      chk("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
      cyc();
      cyc();
      rst = 1'b1;
      // sequential fetch of 4-byte instructions until full
      for (int i = 0; i < 4; i++) begin
         #1 chk("seq_addr", pf_addr, 32'(4 * i));
         cyc();
      end
      #1;
      chk("full_pf_valid", {31'b0, pf_valid}, 32'h0);
      chk("head_pc", dec_pc, 32'h0);
      chk("head_comp", {31'b0, dec_comp}, 32'h0);
      dec_ready = 1'b1;
      cyc();
      dec_ready = 1'b0;
      #1;
      chk("resume_valid", {31'b0, pf_valid}, 32'h1);
      chk("resume_addr", pf_addr, 32'h10);
      chk("after_pop_head", dec_pc, 32'h4);
      cyc();
      // redirect out of a full queue, response in that cycle dropped
      redirect(32'h8000_0100, 1'b0);
      #1;
      chk("redir_dec_valid", {31'b0, dec_valid}, 32'h0);
      chk("redir_addr", pf_addr, 32'h8000_0100);
      cyc();
      // fence pulse, then misses held at the fence address
      redirect(32'h200, 1'b1);
      pf_ready = 1'b0;
      #1;
      chk("fence_valid", {31'b0, pf_valid}, 32'h1);
      chk("fence_pulse", {31'b0, pf_fence}, 32'h1);
      chk("fence_addr", pf_addr, 32'h200);
      cyc();
      for (int i = 0; i < 4; i++) begin
         #1 chk("fence_hold", pf_addr, 32'h200);
         cyc();
      end
      pf_ready = 1'b1;
      cyc();
      // ten misses at 0x40 then a single hit
      redirect(32'h40, 1'b0);
      pf_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1 chk("miss_hold", pf_addr, 32'h40);
         cyc();
      end
      pf_ready = 1'b1;
      cyc();
      pf_ready = 1'b0;
      #1 chk("miss_pc", dec_pc, 32'h40);
      dec_ready = 1'b1;
      cyc();
      dec_ready = 1'b0;
      #1 chk("miss_one", {31'b0, dec_valid}, 32'h0);
      cyc();
      // c.li
      redirect(32'h100, 1'b0);
      pf_ready = 1'b1;
      pf_rdata = 32'h0000_4501;
      cyc();
      pf_ready = 1'b0;
      #1;
      chk("cli_comp", {31'b0, dec_comp}, {31'b0, RVC});
      chk("cli_instr", dec_instr, 32'h0000_4501);
      chk("cli_next", pf_addr, RVC ? 32'h102 : 32'h104);
      cyc();
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(63) != 0);
         redir_valid = ($urandom_range(15) == 0);
         redir_fence = redir_valid && $urandom_range(1) == 1;
         redir_addr = $urandom();
         pf_ready = ($urandom_range(3) != 0);
         dec_ready = ($urandom_range(1) == 1);
         pf_rdata = $urandom();
         if ($urandom_range(1) == 1) pf_rdata[1:0] = 2'b11;
         cyc();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
